// File: rtl/code_fetch_if.sv
// Fetch-side bus: combinational code-memory read port plus the valid/ready
// opcode channel to the decoder. The master is the fetch sequencer.
interface code_fetch_if;
   logic [15:0] mem_ip;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_opcode;
   logic [15:0] out_pc;

   modport master (
      output mem_ip,
      input  mem_rdata,
      output out_valid,
      input  out_ready,
      output out_opcode,
      output out_pc
   );

   modport slave (
      input  mem_ip,
      output mem_rdata,
      input  out_valid,
      output out_ready,
      input  out_opcode,
      input  out_pc
   );
endinterface

// File: rtl/code_fetch.sv
// Code-memory fetch sequencer: start, branch flush, wrap and halt-opcode stop.
// Optional FETCH_COUNT_EN adds a saturating count of accepted instructions.
module code_fetch #(
   parameter int          CODE_DEPTH = 16,
   parameter logic [15:0] HALT_OP    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] start_addr,
   input  logic        br_valid,
   input  logic [15:0] br_target,
   output logic        halted,
`ifdef FETCH_COUNT_EN
   output logic [15:0] fetch_count,
`endif
   code_fetch_if.master bus
);
   localparam int AW = $clog2(CODE_DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_next;
   logic          load_ok;
   logic          accept;
   logic          unused_bits;

   // Only the low address bits reach the memory; upper bits are discarded.
   assign unused_bits = ^{start_addr[15:AW], br_target[15:AW]};

   assign pc_next     = (pc == AW'(CODE_DEPTH - 1)) ? '0 : pc + 1'b1;
   assign bus.mem_ip  = {{(16 - AW){1'b0}}, pc};
   assign load_ok     = !bus.out_valid || bus.out_ready;
   assign accept      = bus.out_valid && bus.out_ready;
   assign halted      = (state == HALT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_opcode <= '0;
         bus.out_pc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.out_valid <= 1'b0;
               if (start) begin
                  pc    <= start_addr[AW-1:0];
                  state <= RUN;
               end
            end
            RUN: begin
               if (br_valid) begin
                  pc            <= br_target[AW-1:0];
                  bus.out_valid <= 1'b0;
               end else if (load_ok) begin
                  bus.out_opcode <= bus.mem_rdata;
                  bus.out_pc     <= bus.mem_ip;
                  bus.out_valid  <= 1'b1;
                  if (bus.mem_rdata == HALT_OP) begin
                     state <= HALT;
                  end else begin
                     pc <= pc_next;
                  end
               end
            end
            HALT: begin
               if (start) begin
                  pc            <= start_addr[AW-1:0];
                  bus.out_valid <= 1'b0;
                  state         <= RUN;
               end else if (accept) begin
                  bus.out_valid <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   // A start that is actually taken clears the count and wins over a same-cycle accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (start && (state != RUN)) begin
         fetch_count <= '0;
      end else if (accept && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_code_fetch.sv
// Directed bench for code_fetch with a 16-word combinational code memory model.
// Count checks are compiled in only when FETCH_COUNT_EN is defined.
module tb_code_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] start_addr;
   logic        br_valid;
   logic [15:0] br_target;
   logic        halted;
`ifdef FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif
   logic [15:0] mem [16];

   int checks = 0;
   int errors = 0;

   code_fetch_if bus ();

   assign bus.mem_rdata = mem[bus.mem_ip[3:0]];

   code_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .halted     (halted),
`ifdef FETCH_COUNT_EN
      .fetch_count(fetch_count),
`endif
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] op, input logic [15:0] pc);
      check({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
      check({tag, "_op"}, bus.out_opcode, op);
      check({tag, "_pc"}, bus.out_pc, pc);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h2000 + 16'(i);
      for (int i = 0; i < 4; i++) mem[i] = 16'h1000 + 16'(i);
      mem[4]        = 16'hFFFF;
      rst_n         = 1'b0;
      start         = 1'b0;
      start_addr    = 16'h0000;
      br_valid      = 1'b0;
      br_target     = 16'h0000;
      bus.out_ready = 1'b0;
      step();
      step();
      check("rst_valid", {15'd0, bus.out_valid}, 16'd0);
      check("rst_op", bus.out_opcode, 16'h0000);
      check("rst_pc", bus.out_pc, 16'h0000);
      check("rst_ip", bus.mem_ip, 16'h0000);
      check("rst_halted", {15'd0, halted}, 16'd0);

      // Straight-line run ending in the halt opcode
      rst_n = 1'b1; bus.out_ready = 1'b1; start = 1'b1; start_addr = 16'h0000;
      step();
      start = 1'b0;
      check("run_first_valid", {15'd0, bus.out_valid}, 16'd0);
      check("run_first_ip", bus.mem_ip, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("run", 16'h1000 + 16'(i), 16'(i));
         check("run_halted", {15'd0, halted}, 16'd0);
      end
      step();
      expect_out("run_halt", 16'hFFFF, 16'h0004);
      check("run_halted_set", {15'd0, halted}, 16'd1);
      check("run_halt_ip", bus.mem_ip, 16'h0004);
      step();
      check("halt_acc_valid", {15'd0, bus.out_valid}, 16'd0);
      check("halt_acc_halted", {15'd0, halted}, 16'd1);
`ifdef FETCH_COUNT_EN
      check("run_count", fetch_count, 16'd5);
`endif

      // Backpressure with no bubble on release
      start = 1'b1; start_addr = 16'h0000;
      step();
      start = 1'b0;
      check("bp_restart_halted", {15'd0, halted}, 16'd0);
      step();
      expect_out("bp_1000", 16'h1000, 16'h0000);
      step();
      expect_out("bp_1001", 16'h1001, 16'h0001);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("bp_hold", 16'h1001, 16'h0001);
         check("bp_hold_ip", bus.mem_ip, 16'h0002);
      end
      bus.out_ready = 1'b1;
      step();
      expect_out("bp_release", 16'h1002, 16'h0002);
`ifdef FETCH_COUNT_EN
      check("bp_count", fetch_count, 16'd2);
`endif

      // Branch flush while stalled
      bus.out_ready = 1'b0; br_valid = 1'b1; br_target = 16'h000A;
      step();
      br_valid = 1'b0;
      check("br_flush_valid", {15'd0, bus.out_valid}, 16'd0);
      check("br_flush_ip", bus.mem_ip, 16'h000A);
      bus.out_ready = 1'b1;
      step();
      expect_out("br_target", 16'h200A, 16'h000A);
`ifdef FETCH_COUNT_EN
      check("br_count_flushed", fetch_count, 16'd2);
`endif
      step();
      expect_out("br_next", 16'h200B, 16'h000B);
`ifdef FETCH_COUNT_EN
      check("br_count_next", fetch_count, 16'd3);
`endif

      // Reset in the middle of a run
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
      check("mid_rst_op", bus.out_opcode, 16'h0000);
      check("mid_rst_ip", bus.mem_ip, 16'h0000);
      check("mid_rst_halted", {15'd0, halted}, 16'd0);
      step();
      step();
      check("idle_no_fetch", {15'd0, bus.out_valid}, 16'd0);
      check("idle_ip", bus.mem_ip, 16'h0000);
`ifdef FETCH_COUNT_EN
      check("mid_rst_count", fetch_count, 16'd0);
`endif

      // Wrap-around with masked start address
      mem[4] = 16'h1004;
      start = 1'b1; start_addr = 16'h001E;
      step();
      start = 1'b0;
      check("wrap_start_ip", bus.mem_ip, 16'h000E);
      step();
      expect_out("wrap_14", 16'h200E, 16'h000E);
      check("wrap_ip15", bus.mem_ip, 16'h000F);
      step();
      expect_out("wrap_15", 16'h200F, 16'h000F);
      check("wrap_ip0", bus.mem_ip, 16'h0000);
      step();
      expect_out("wrap_0", 16'h1000, 16'h0000);
      step();
      expect_out("wrap_1", 16'h1001, 16'h0001);
      check("wrap_ip2", bus.mem_ip, 16'h0002);

      // Restart from HALT while the halt opcode is still unaccepted
      mem[3] = 16'hFFFF;
      step();
      expect_out("rs_2", 16'h1002, 16'h0002);
      step();
      expect_out("rs_halt", 16'hFFFF, 16'h0003);
      check("rs_halted", {15'd0, halted}, 16'd1);
      mem[3] = 16'h1003;
      bus.out_ready = 1'b0; br_valid = 1'b1; br_target = 16'h0007;
      step();
      br_valid = 1'b0;
      expect_out("rs_hold", 16'hFFFF, 16'h0003);
      check("rs_br_ignored_ip", bus.mem_ip, 16'h0003);
      start = 1'b1; start_addr = 16'h0003;
      step();
      start = 1'b0;
      check("rs_halted_clr", {15'd0, halted}, 16'd0);
      check("rs_dropped", {15'd0, bus.out_valid}, 16'd0);
      check("rs_ip", bus.mem_ip, 16'h0003);
      bus.out_ready = 1'b1;
      step();
      expect_out("rs_first", 16'h1003, 16'h0003);
`ifdef FETCH_COUNT_EN
      check("rs_count_clr", fetch_count, 16'd0);
      step();
      check("rs_count_one", fetch_count, 16'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/code_fetch.md
Name: code_fetch

Overview:
- Read-side sequencer for the 16-entry code memory.
- Drives the instruction pointer onto the memory's combinational read port and captures the returned opcode into an output register.
- Presents the opcode with a valid/ready handshake to the decoder.
- Handles start, branch redirect/flush, wrap-around and halt-opcode detection. The memory's write port belongs to the loader and is not touched here.

Parameters:
- CODE_DEPTH, 16, number of code words; must be a power of two, at least 2.
- HALT_OP, 16'hFFFF, opcode value that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- start  input  1  one-cycle pulse; begin fetching at start_addr.
- start_addr  input  16  first fetch address.
- mem_ip  output  16  address to code memory read port; equals pc, combinational.
- mem_rdata  input  16  opcode returned combinationally for mem_ip.
- br_valid  input  1  redirect request.
- br_target  input  16  redirect address.
- out_valid  output  1  out_opcode/out_pc hold a fetched instruction.
- out_ready  input  1  decoder accepts when out_valid && out_ready.
- out_opcode  output  16  fetched opcode.
- out_pc  output  16  address out_opcode was fetched from.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, pc=0, out_valid=0, out_opcode=0, out_pc=0, halted=0. Reset mid-fetch discards the pending instruction with no accept.
- Address masking: start_addr and br_target are masked to log2(CODE_DEPTH) low bits; pc upper bits are always 0.
- pc increment: pc_next = (pc == CODE_DEPTH-1) ? 0 : pc+1, i.e. wrap.
- load_ok = !out_valid || out_ready. This gives full throughput of one instruction per cycle with no bubble.
- IDLE:
  - out_valid=0.
  - start: pc=start_addr, go RUN.
  - br_valid is ignored.
- RUN, checked in priority order each posedge:
  1. br_valid: pc=br_target and out_valid=0 (flush), regardless of out_ready. If out_valid && out_ready in the same cycle, that instruction counts as consumed; the flush only prevents a new load. No load this cycle. First instruction from the target appears one cycle later.
  2. load_ok: out_opcode=mem_rdata, out_pc=pc, out_valid=1. Then:
     - If mem_rdata==HALT_OP: pc holds and state goes to HALT.
     - Otherwise pc=pc_next.
  3. Otherwise (stall): all registers hold. mem_ip stays stable while stalled.
- start during RUN is ignored.
- HALT:
  - halted=1.
  - The halt opcode remains presented; out_valid clears on its accept.
  - No further loads; br_valid is ignored.
  - start: pc=start_addr, out_valid=0, halted=0, go RUN. This discards a still-unaccepted halt opcode.
- Latency: RUN entered at cycle N gives out_valid=1 at cycle N+1, with opcode=Code[start_addr].
- Output stability: out_opcode/out_pc are stable while out_valid && !out_ready.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined:
  - Adds output fetch_count [15:0]: counts handshakes (out_valid && out_ready), saturating at 16'hFFFF.
  - Reset value is 0; it is also cleared by start.
  - Flushed (never accepted) instructions are not counted.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Straight-line run:
  - Stimulus: memory[0..3]=16'h1000..16'h1003, memory[4]=16'hFFFF, out_ready=1, start with start_addr=0.
  - Response: opcodes 1000,1001,1002,1003,FFFF on consecutive cycles with out_pc 0..4. halted=1 the cycle after FFFF is loaded. out_valid=0 after FFFF is accepted. fetch_count=5.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while out_opcode=16'h1001.
  - Response: out_opcode, out_pc=1 and mem_ip=2 are held. On release, 1001 is accepted, followed by 1002 the next cycle with no bubble.
- Branch flush:
  - Stimulus: br_valid=1 with br_target=16'h000A while out_valid=1 and out_ready=0.
  - Response: out_valid=0 next cycle; next instruction has out_pc=10; the flushed instruction is not counted.
- Wrap and mask:
  - Stimulus: start_addr=16'h001E with no HALT_OP present.
  - Response: out_pc sequence 14,15,0,1; mem_ip never exceeds 15.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one cycle during RUN with out_valid=1.
  - Response: out_valid=0, out_opcode=0, mem_ip=0, state IDLE. No fetch until the next start.
- Restart from HALT:
  - Stimulus: start with start_addr=3 while halted and the halt opcode is unaccepted.
  - Response: halted=0, halt opcode dropped, next output has out_pc=3.
